// File: rtl/qround_pipe.sv
// qround_pipe: drops NBITS LSBs from a valid/ready stream using truncate,
// round-half-up or round-half-even rounding. Overflow saturates, the output
// is optionally compacted to DIN-NBITS bits, and a 2-entry skid buffer keeps
// din_ready registered so there is no combinational path from dout_ready.
// Optional feature macro: QROUND_SAT_CNT_EN adds a sticky 16-bit count of
// saturated output beats with a synchronous clear input.
module qround_pipe #(
    parameter int DIN    = 16,
    parameter int NBITS  = 4,
    parameter int SIGNED = 1,
    parameter int MODE   = 0,
    parameter int SHIFT  = 0,
    localparam int OW    = (SHIFT != 0) ? (DIN - NBITS) : DIN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DIN-1:0] din_data,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [OW-1:0] dout_data,
    output logic          dout_sat
`ifdef QROUND_SAT_CNT_EN
    ,
    input  logic          sat_cnt_clr,
    output logic [15:0]   sat_cnt
`endif
);

    localparam int KW = DIN - NBITS;
    localparam logic [KW-1:0] SMAX = {KW{1'b1}} >> 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    logic [KW-1:0] k;
    logic          g;
    logic          s;
    logic          inc;
    logic [KW:0]   r_wide;
    logic          ovf;
    logic [KW-1:0] sat_val;
    logic [KW-1:0] r_fin;
    logic [OW-1:0] round_data;

    skid_state_t   state_q;
    skid_state_t   state_d;
    logic          din_ready_q;
    logic          dout_valid_q;
    logic [OW-1:0] out_data_q;
    logic          out_sat_q;
    logic [OW-1:0] skid_data_q;
    logic          skid_sat_q;
    logic          in_fire;
    logic          out_fire;
    logic          load_out;
    logic          load_skid;
    logic          out_from_skid;

    // Split the sample into kept part K, guard bit G and sticky bit S.
    if (NBITS == 0) begin : g_nodrop
        assign k = din_data;
        assign g = 1'b0;
        assign s = 1'b0;
    end else if (NBITS == 1) begin : g_drop1
        assign k = din_data[DIN-1:1];
        assign g = din_data[0];
        assign s = 1'b0;
    end else begin : g_dropn
        assign k = din_data[DIN-1:NBITS];
        assign g = din_data[NBITS-1];
        assign s = |din_data[NBITS-2:0];
    end

    // Round K one bit wider than itself, then clamp to the K range on overflow.
    always_comb begin
        inc     = 1'b0;
        r_wide  = '0;
        ovf     = 1'b0;
        sat_val = '1;
        case (MODE)
            0:       inc = 1'b0;
            1:       inc = g;
            default: inc = g & (s | k[0]);
        endcase
        if (SIGNED != 0) begin
            r_wide  = {k[KW-1], k} + {{KW{1'b0}}, inc};
            ovf     = r_wide[KW] ^ r_wide[KW-1];
            sat_val = SMAX;
        end else begin
            r_wide  = {1'b0, k} + {{KW{1'b0}}, inc};
            ovf     = r_wide[KW];
            sat_val = '1;
        end
        r_fin = ovf ? sat_val : r_wide[KW-1:0];
    end

    if (SHIFT != 0) begin : g_shift
        assign round_data = r_fin;
    end else begin : g_noshift
        logic [DIN-1:0] full;

        // Re-insert zero LSBs so the output keeps the input's scaling.
        always_comb begin
            full              = '0;
            full[DIN-1:NBITS] = r_fin;
        end

        assign round_data = full;
    end

    assign in_fire  = din_valid & din_ready_q;
    assign out_fire = dout_valid_q & dout_ready;

    // Skid next-state and register load selects; ready/valid follow the next state.
    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_out = 1'b1;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    out_from_skid = 1'b1;
                    state_d       = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State, handshake flags and the two data registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= EMPTY;
            din_ready_q  <= 1'b1;
            dout_valid_q <= 1'b0;
            out_data_q   <= '0;
            out_sat_q    <= 1'b0;
            skid_data_q  <= '0;
            skid_sat_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            din_ready_q  <= (state_d != FULL);
            dout_valid_q <= (state_d != EMPTY);
            if (load_out) begin
                out_data_q <= round_data;
                out_sat_q  <= ovf;
            end else if (out_from_skid) begin
                out_data_q <= skid_data_q;
                out_sat_q  <= skid_sat_q;
            end
            if (load_skid) begin
                skid_data_q <= round_data;
                skid_sat_q  <= ovf;
            end
        end
    end

    assign din_ready  = din_ready_q;
    assign dout_valid = dout_valid_q;
    assign dout_data  = out_data_q;
    assign dout_sat   = out_sat_q;

`ifdef QROUND_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    // Sticky count of saturated beats taken downstream; clear beats increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sat_cnt_q <= '0;
        end else if (sat_cnt_clr) begin
            sat_cnt_q <= '0;
        end else if (out_fire && out_sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_qround_pipe.sv
// tb_qround_pipe: directed self-checking bench for qround_pipe.
// Six instances (DIN=8) share one input stream; their outputs are packed
// A..F from MSB to LSB and compared as whole vectors:
//   A unsigned MODE0 SHIFT0, B signed MODE1 SHIFT0, C signed MODE1 SHIFT1,
//   D signed MODE2 SHIFT0, E unsigned MODE2 SHIFT0, F NBITS=0 unsigned MODE1.
module tb_qround_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic [7:0]  din_data;
    logic        dout_ready;

    logic [5:0]  din_ready;
    logic [5:0]  dout_valid;
    logic [5:0]  dout_sat;
    logic [7:0]  dout_a, dout_b, dout_d, dout_e, dout_f;
    logic [3:0]  dout_c;
    logic [47:0] obs_data;

    int checks = 0;
    int errors = 0;

`ifdef QROUND_SAT_CNT_EN
    logic        sat_cnt_clr;
    logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d, cnt_e, cnt_f;
`endif

    always #5 clk = ~clk;

    assign obs_data = {dout_a, dout_b, {4'h0, dout_c}, dout_d, dout_e, dout_f};

    qround_pipe #(.DIN(8), .NBITS(4), .SIGNED(0), .MODE(0), .SHIFT(0)) u_a (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready[5]),
        .din_data(din_data), .dout_valid(dout_valid[5]), .dout_ready(dout_ready),
        .dout_data(dout_a), .dout_sat(dout_sat[5])
`ifdef QROUND_SAT_CNT_EN
        , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(cnt_a)
`endif
    );

    qround_pipe #(.DIN(8), .NBITS(4), .SIGNED(1), .MODE(1), .SHIFT(0)) u_b (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready[4]),
        .din_data(din_data), .dout_valid(dout_valid[4]), .dout_ready(dout_ready),
        .dout_data(dout_b), .dout_sat(dout_sat[4])
`ifdef QROUND_SAT_CNT_EN
        , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(cnt_b)
`endif
    );

    qround_pipe #(.DIN(8), .NBITS(4), .SIGNED(1), .MODE(1), .SHIFT(1)) u_c (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready[3]),
        .din_data(din_data), .dout_valid(dout_valid[3]), .dout_ready(dout_ready),
        .dout_data(dout_c), .dout_sat(dout_sat[3])
`ifdef QROUND_SAT_CNT_EN
        , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(cnt_c)
`endif
    );

    qround_pipe #(.DIN(8), .NBITS(4), .SIGNED(1), .MODE(2), .SHIFT(0)) u_d (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready[2]),
        .din_data(din_data), .dout_valid(dout_valid[2]), .dout_ready(dout_ready),
        .dout_data(dout_d), .dout_sat(dout_sat[2])
`ifdef QROUND_SAT_CNT_EN
        , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(cnt_d)
`endif
    );

    qround_pipe #(.DIN(8), .NBITS(4), .SIGNED(0), .MODE(2), .SHIFT(0)) u_e (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready[1]),
        .din_data(din_data), .dout_valid(dout_valid[1]), .dout_ready(dout_ready),
        .dout_data(dout_e), .dout_sat(dout_sat[1])
`ifdef QROUND_SAT_CNT_EN
        , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(cnt_e)
`endif
    );

    qround_pipe #(.DIN(8), .NBITS(0), .SIGNED(0), .MODE(1), .SHIFT(0)) u_f (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready[0]),
        .din_data(din_data), .dout_valid(dout_valid[0]), .dout_ready(dout_ready),
        .dout_data(dout_f), .dout_sat(dout_sat[0])
`ifdef QROUND_SAT_CNT_EN
        , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(cnt_f)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_output(input string tag, input logic [47:0] ed, input logic [5:0] es);
        check({tag, "/valid"}, 64'(dout_valid), 64'(6'h3F));
        check({tag, "/data"},  64'(obs_data),   64'(ed));
        check({tag, "/sat"},   64'(dout_sat),   64'(es));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "/idle"}, 64'(dout_valid), 64'(6'h00));
    endtask

    task automatic check_ready(input string tag, input logic [5:0] er);
        check({tag, "/ready"}, 64'(din_ready), 64'(er));
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] d);
        din_valid = v;
        din_data  = d;
    endtask

    // One isolated beat: idle before accept, output exactly one cycle later.
    task automatic send_single(input string tag, input logic [7:0] d,
                               input logic [47:0] ed, input logic [5:0] es);
        @(negedge clk);
        check_idle({tag, "/pre"});
        check_ready(tag, 6'h3F);
        apply_stimulus(1'b1, d);
        @(negedge clk);
        apply_stimulus(1'b0, 8'h00);
        check_output(tag, ed, es);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        dout_ready = 1'b1;
        apply_stimulus(1'b0, 8'h00);
`ifdef QROUND_SAT_CNT_EN
        sat_cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_idle("reset");
        check_ready("reset", 6'h3F);
        check("reset/data", 64'(obs_data), 64'h0);
        check("reset/sat", 64'(dout_sat), 64'h0);

        // Rounding vectors across all six configurations.
        send_single("v5F", 8'h5F, 48'h50_60_06_60_60_5F, 6'b000000);
        send_single("v50", 8'h50, 48'h50_50_05_50_50_50, 6'b000000);
        send_single("vFF", 8'hFF, 48'hF0_00_00_00_F0_FF, 6'b000010);
        send_single("v58", 8'h58, 48'h50_60_06_60_60_58, 6'b000000);
        send_single("v57", 8'h57, 48'h50_50_05_50_50_57, 6'b000000);
        send_single("vF8", 8'hF8, 48'hF0_00_00_00_F0_F8, 6'b000010);
        send_single("v78", 8'h78, 48'h70_70_07_70_80_78, 6'b011100);
        send_single("v68", 8'h68, 48'h60_70_07_60_60_68, 6'b000000);
        send_single("v69", 8'h69, 48'h60_70_07_70_70_69, 6'b000000);
        send_single("v48", 8'h48, 48'h40_50_05_40_40_48, 6'b000000);
        send_single("v88", 8'h88, 48'h80_90_09_80_80_88, 6'b000000);

        // Back-to-back stream at full throughput.
        @(negedge clk);
        apply_stimulus(1'b1, 8'h5F);
        @(negedge clk);
        apply_stimulus(1'b1, 8'h50);
        check_output("stream0", 48'h50_60_06_60_60_5F, 6'b000000);
        check_ready("stream0", 6'h3F);
        @(negedge clk);
        apply_stimulus(1'b1, 8'hFF);
        check_output("stream1", 48'h50_50_05_50_50_50, 6'b000000);
        @(negedge clk);
        apply_stimulus(1'b0, 8'h00);
        check_output("stream2", 48'hF0_00_00_00_F0_FF, 6'b000010);
        @(negedge clk);
        check_idle("stream_end");

        // Backpressure: two beats fill the buffer, the third waits.
        dout_ready = 1'b0;
        apply_stimulus(1'b1, 8'h10);
        check_ready("bp0", 6'h3F);
        @(negedge clk);
        apply_stimulus(1'b1, 8'h20);
        check_ready("bp1", 6'h3F);
        check_output("bp1", 48'h10_10_01_10_10_10, 6'b000000);
        @(negedge clk);
        apply_stimulus(1'b1, 8'h30);
        check_ready("bp2", 6'h00);
        check_output("bp2", 48'h10_10_01_10_10_10, 6'b000000);
        @(negedge clk);
        check_ready("bp3", 6'h00);
        check_output("bp3", 48'h10_10_01_10_10_10, 6'b000000);
        dout_ready = 1'b1;
        @(negedge clk);
        check_output("bp4", 48'h20_20_02_20_20_20, 6'b000000);
        check_ready("bp4", 6'h3F);
        @(negedge clk);
        apply_stimulus(1'b0, 8'h00);
        check_output("bp5", 48'h30_30_03_30_30_30, 6'b000000);
        @(negedge clk);
        check_idle("bp6");

        // Reset while FULL discards both buffered beats.
        dout_ready = 1'b0;
        apply_stimulus(1'b1, 8'h58);
        @(negedge clk);
        apply_stimulus(1'b1, 8'h69);
        @(negedge clk);
        apply_stimulus(1'b0, 8'h00);
        check_ready("midrst_full", 6'h00);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_idle("midrst");
        check_ready("midrst", 6'h3F);
        check("midrst/data", 64'(obs_data), 64'h0);
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("midrst_after");
        end

`ifdef QROUND_SAT_CNT_EN
        // Saturation counter: count, clear priority, sticky top value.
        check("satcnt0", 64'({cnt_b, cnt_c, cnt_d}), 64'h0);
        for (int i = 0; i < 3; i++) begin
            send_single("sat", 8'h78, 48'h70_70_07_70_80_78, 6'b011100);
        end
        @(negedge clk);
        check("satcnt3", 64'({cnt_b, cnt_c, cnt_d}), 64'h0003_0003_0003);
        sat_cnt_clr = 1'b1;
        send_single("satclr", 8'h78, 48'h70_70_07_70_80_78, 6'b011100);
        @(negedge clk);
        sat_cnt_clr = 1'b0;
        check("satclr", 64'({cnt_b, cnt_c, cnt_d}), 64'h0);
        apply_stimulus(1'b1, 8'h78);
        repeat (65535) @(negedge clk);
        apply_stimulus(1'b0, 8'h00);
        @(negedge clk);
        check("satmax", 64'({cnt_b, cnt_c, cnt_d}), 64'hFFFF_FFFF_FFFF);
        send_single("satstick", 8'h78, 48'h70_70_07_70_80_78, 6'b011100);
        @(negedge clk);
        check("satstick", 64'({cnt_b, cnt_c, cnt_d}), 64'hFFFF_FFFF_FFFF);
        check("satnone", 64'({cnt_a, cnt_e, cnt_f}), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qround_pipe.md
Name: qround_pipe

Overview:
Parametrised successor to the plain LSB-truncation stage. Drops NBITS LSBs from a valid/ready stream using one of three rounding modes. Saturates on rounding overflow, optionally compacts the output width, and registers the output through a 2-entry skid buffer so no combinational path runs from dout_ready to din_ready. Sits between DSP datapath stages, e.g. after accumulators and before narrower consumers.

Parameters:
DIN, 16, input data width.
NBITS, 4, number of LSBs removed; legal range 0 <= NBITS < DIN.
SIGNED, 1, 1 = two's-complement input, 0 = unsigned.
MODE, 0, 0 = truncate, 1 = round-half-up, 2 = round-half-even.
SHIFT, 0, 0 = output DIN bits with NBITS zero LSBs; 1 = output DOUT = DIN-NBITS bits, right-aligned.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
din_valid  in  1  input beat valid
din_ready  out  1  input ready; driven from a register
din_data  in  DIN  input sample
dout_valid  out  1  output beat valid
dout_ready  in  1  downstream ready
dout_data  out  SHIFT ? DIN-NBITS : DIN  rounded sample
dout_sat  out  1  current output beat was saturated

Behaviour:
- One clock. Reset is synchronous and active-low: applied when rst==0 on a clk rising edge.
- Reset values: dout_valid=0, dout_data=0, dout_sat=0, din_ready=1, skid state EMPTY. The optional sat_cnt resets to 0.
- Reset mid-operation: all buffered beats are discarded and no output is emitted afterwards.
- Handshake: a transfer occurs when valid&&ready on a rising edge. Once dout_valid is asserted, dout_data and dout_sat are held stable until accepted.
- Latency: 1 cycle, din accept to dout_valid. Full throughput, 1 beat/cycle, while dout_ready=1.
- Arithmetic, with K = din_data[DIN-1:NBITS], G = bit NBITS-1, S = |bits[NBITS-2:0]:
  - MODE0: R = K.
  - MODE1: R = K + G.
  - MODE2: R = K + (G && (S || K[0])).
  - R is computed 1 bit wider than K.
- Saturation:
  - Unsigned: if R exceeds the K range, R = all-ones.
  - Signed: if R > max positive, R = max positive. Negative values cannot overflow.
  - dout_sat=1 only for the saturated beat.
- NBITS=0: G=S=0, so every mode is a passthrough and dout_sat is never set.
- Output formatting: SHIFT=0 gives dout_data = {R[DOUT-1:0], NBITS'b0}. SHIFT=1 gives dout_data = R[DOUT-1:0].
- Skid FSM:
  - EMPTY: output register empty. dout_valid=0, din_ready=1. On accept -> ONE.
  - ONE: output register holds a beat.
    - din accepted and dout taken: stay in ONE, output register reloads.
    - din accepted, dout not taken: new beat goes to the skid register -> FULL; din_ready deasserts next cycle.
    - dout taken, no din accepted -> EMPTY.
  - FULL: din_ready=0.
    - dout taken: skid moves to the output register -> ONE; din_ready=1 next cycle.
- Rounding is computed before buffering, so both registers hold final values.
- Beat order is always preserved.

Optional Feature:
QROUND_SAT_CNT_EN:
- Defined: adds input sat_cnt_clr (1 bit) and output sat_cnt (16 bits).
  - sat_cnt increments by 1 for each saturated beat accepted at the output (dout_valid && dout_ready && dout_sat).
  - It sticks at 0xFFFF.
  - sat_cnt_clr=1 clears it to 0; clear wins over a simultaneous increment.
  - rst clears it.
- Undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Test Plan:
1. DIN=8, NBITS=4, MODE0, SHIFT=0, unsigned: din 0x5F, 0x50, 0xFF -> dout 0x50, 0x50, 0xF0, each 1 cycle after accept, dout_sat=0.
2. MODE1, SIGNED=1: din 0x58 -> 0x60; din 0x57 -> 0x50; din 0xF8 (-0.5) -> 0x00; din 0x78 -> 0x70 with dout_sat=1. Same with SHIFT=1 -> 0x6, 0x5, 0x0, 0x7.
3. MODE2: din 0x58 -> 0x60; 0x68 -> 0x60; 0x69 -> 0x70; 0x48 -> 0x40. Unsigned 0xF8 -> 0xF0 with dout_sat=1.
4. Backpressure: dout_ready=0, present din_valid with beats 0x10, 0x20, 0x30 -> first two accepted, din_ready=0 from the cycle after the second accept, 0x30 held. Then raise dout_ready -> outputs 0x10, 0x20, 0x30 in order on consecutive cycles, no loss or duplication.
5. Reset mid-operation: reach FULL, then pull rst=0 for 1 cycle -> dout_valid=0 and din_ready=1 the next cycle; the stale beats never appear.
6. With QROUND_SAT_CNT_EN: 3 saturating beats accepted -> sat_cnt=3; assert sat_cnt_clr together with a 4th saturating accept -> sat_cnt=0. Force the count to 0xFFFF, then one more saturating beat -> stays 0xFFFF.
